sequential_scaler: RTL and testbench
====================================

// Module: sequential_scaler
// PURPOSE
//  Shift-add multiplier that applies the 8-bit fractional gain produced by the
//  sequential divider stage to a 16-bit unsigned audio sample.
//  Computes result = (sample * gain) >> GAIN_W over GAIN_W cycles, one gain bit per cycle.
//  Sits directly downstream of the divider, before the output mixer / PWM stage.
//  Uses a start/busy/done handshake so the voice sequencer can run it back-to-back.
// PARAMETERS
//  SAMPLE_W  16  width of sample operand and of result
//  GAIN_W    8   width of gain operand (fraction, gain/2^GAIN_W); also iteration count
// PORTS
//  clk     in   1         system clock, rising edge
//  rst     in   1         synchronous active-high reset
//  start   in   1         request; sampled only in IDLE or DONE
//  sample  in   SAMPLE_W  unsigned sample, latched on accepted start
//  gain    in   GAIN_W    unsigned fractional gain (divider quotient), latched on accepted start
//  busy    out  1         high while in CALC
//  done    out  1         one-cycle pulse, result valid
//  result  out  SAMPLE_W  scaled sample, held until next done
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous and active-high.
//  Reset (rst=1 at a rising edge, any state, including mid-CALC):
//   - state=IDLE; busy=0, done=0, result=0; accumulator, operand regs, count cleared.
//   - rst has priority over start.
//  FSM states: IDLE, CALC, DONE.
//   - IDLE: start=1 -> latch sample/gain, acc=0, count=0, go CALC; else stay.
//   - CALC, each cycle: if gain_reg[count]=1, acc += sample_reg << count.
//     Then count++. When count==GAIN_W-1, go DONE and register result from final acc.
//   - DONE: done=1 for exactly this cycle. result = acc[SAMPLE_W+GAIN_W-1:GAIN_W].
//     start=1 -> accept new operands, go CALC (back-to-back). Else go IDLE.
//  Timing:
//   - start accepted at edge k -> CALC for GAIN_W cycles -> done high in cycle after edge k+GAIN_W.
//   - Throughput: one result per GAIN_W+1 cycles.
//  Operands:
//   - start while busy=1 is ignored; operand inputs may change freely during CALC.
//  Arithmetic and widths:
//   - acc is SAMPLE_W+GAIN_W bits (24); max product 0xFFFF*0xFF fits, no overflow, no saturation.
//   - result is truncated (floor), not rounded.
//  Outputs:
//   - busy is high only in CALC.
//   - result changes only when entering DONE (or on reset); stable at all other times.
//  Boundary cases:
//   - gain=0 -> result 0. sample=0 -> result 0.
//   - gain=all-ones -> result = sample - ceil(sample/256) for nonzero sample, i.e. floor(sample*255/256).
//  count width = $clog2(GAIN_W); no other state encodings reachable; illegal state -> IDLE.
// TESTING
//  1. sample=0x1000, gain=0x80, start pulse -> busy 8 cycles, done on 9th cycle, result=0x0800.
//  2. sample=0xFFFF, gain=0xFF -> result=0xFEFF; no overflow.
//  3. gain=0x00, sample=0xABCD -> result=0x0000; previous nonzero result held until that done.
//  4. start during CALC with new operands -> ignored; result matches original operands, done once.
//  5. start held high in DONE -> second op starts immediately; second done 9 cycles after first.
//  6. rst=1 mid-CALC (count=3) -> next cycle IDLE, busy=0, done=0, result=0; no done pulse follows.

Source files
------------

// File: rtl/sequential_scaler.sv
// Shift-add scaler: result = (sample * gain) >> GAIN_W, one gain bit per clock.
// Start/busy/done handshake allows back-to-back operation straight out of DONE.
module sequential_scaler #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [GAIN_W-1:0]   gain,
    output logic                busy,
    output logic                done,
    output logic [SAMPLE_W-1:0] result
);

    localparam int ACC_W = SAMPLE_W + GAIN_W;
    localparam int CNT_W = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GAIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SAMPLE_W-1:0] r_sample;
    logic [GAIN_W-1:0]   r_gain;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_count;
    logic [SAMPLE_W-1:0] r_result;

    logic                w_accept;
    logic                w_last;
    logic [ACC_W-1:0]    w_addend;
    logic [ACC_W-1:0]    w_acc_sum;

    // Operands are only taken when no calculation is in flight.
    assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last    = (r_count == LAST_CNT);
    assign w_addend  = r_gain[r_count] ? ({{GAIN_W{1'b0}}, r_sample} << r_count) : '0;
    assign w_acc_sum = r_acc + w_addend;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = start ? S_CALC : S_IDLE;
            S_CALC:  w_state_next = w_last ? S_DONE : S_CALC;
            S_DONE:  w_state_next = start ? S_CALC : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
            r_gain   <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_sample <= sample;
                r_gain   <= gain;
                r_acc    <= '0;
                r_count  <= '0;
            end else if (r_state == S_CALC) begin
                r_acc   <= w_acc_sum;
                r_count <= r_count + CNT_W'(1);
                // Final partial product goes straight into the result register.
                if (w_last) begin
                    r_result <= w_acc_sum[ACC_W-1:GAIN_W];
                end
            end
        end
    end

    assign busy   = (r_state == S_CALC);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_sequential_scaler.sv
// Bench for sequential_scaler: cycle-level reference model plus directed operations
// with hand-computed literal results.
module tb_sequential_scaler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] sample = '0;
    logic [7:0]  gain = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    sequential_scaler #(.SAMPLE_W(16), .GAIN_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sample (sample),
        .gain   (gain),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference model: cycles left in the current calculation, pending product.
    int          cyc = 0;
    int          m_left = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_result = '0;
    logic        m_done = 1'b0;
    int          n_done = 0;
    int          last_done_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_result = '0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0) m_result = m_pend;
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_left = 8;
                m_pend = 16'((32'(sample) * 32'(gain)) >> 8);
            end
        end
        #1;
        n_tests++;
        if (busy !== (m_left > 0) || done !== m_done || result !== m_result) begin
            n_fail++;
            $display("FAIL cycle%0d outputs: got busy=%b done=%b result=%h, want busy=%b done=%b result=%h",
                     cyc, busy, done, result, (m_left > 0), m_done, m_result);
        end
        if (done === 1'b1) begin
            n_done++;
            last_done_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s timeout: got no done, want done within 20 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] s, input logic [7:0] g,
                          input logic [15:0] lit);
        @(negedge clk);
        start = 1'b1; sample = s; gain = g;
        @(negedge clk);
        start = 1'b0; sample = 16'($urandom); gain = 8'($urandom);
        wait_done(name);
        check(name, 32'(result), 32'(lit));
        check({name, "_model"}, 32'(m_result), 32'(lit));
        $display("[TB] op %s sample=%h gain=%h result=%h", name, s, g, result);
    endtask

    typedef struct { logic [15:0] s; logic [7:0] g; logic [15:0] r; } vec_t;
    vec_t vecs [6] = '{
        '{16'h0001, 8'hFF, 16'h0000},
        '{16'h0100, 8'hFF, 16'h00FF},
        '{16'h0000, 8'h55, 16'h0000},
        '{16'h00FF, 8'h01, 16'h0000},
        '{16'hFFFF, 8'h01, 16'h00FF},
        '{16'h1234, 8'h40, 16'h048D}
    };

    initial begin
        int d1;
        int nd;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        rst = 1'b0;

        run_op("t1_half", 16'h1000, 8'h80, 16'h0800);
        run_op("t2_max", 16'hFFFF, 8'hFF, 16'hFEFF);
        run_op("t3_gain0", 16'hABCD, 8'h00, 16'h0000);
        foreach (vecs[i]) run_op("table", vecs[i].s, vecs[i].g, vecs[i].r);

        // Start during CALC must be ignored.
        nd = n_done;
        @(negedge clk); start = 1'b1; sample = 16'h1234; gain = 8'h40;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; sample = 16'hFFFF; gain = 8'hFF;
        @(negedge clk); start = 1'b0;
        wait_done("t4_ignore");
        check("t4_result", 32'(result), 32'h048D);
        repeat (12) @(negedge clk);
        check("t4_done_count", 32'(n_done - nd), 32'd1);
        $display("[TB] op t4_ignore result=%h dones=%0d", result, n_done - nd);

        // Back-to-back: start held in DONE.
        run_op("t5_first", 16'h1000, 8'h80, 16'h0800);
        d1 = last_done_cyc;
        start = 1'b1; sample = 16'h8000; gain = 8'h03;
        @(negedge clk); start = 1'b0;
        wait_done("t5_second");
        check("t5_result", 32'(result), 32'h0180);
        check("t5_spacing", 32'(last_done_cyc - d1), 32'd9);
        $display("[TB] op t5_b2b result=%h spacing=%0d", result, last_done_cyc - d1);

        // Reset mid-calculation.
        nd = n_done;
        @(negedge clk); start = 1'b1; sample = 16'hFFFF; gain = 8'hFF;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_result", 32'(result), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_no_done", 32'(n_done - nd), 32'd0);
        $display("[TB] op t6_reset busy=%b result=%h dones=%0d", busy, result, n_done - nd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
